ucore_port_responder: RTL and testbench
=======================================

Name: ucore_port_responder

Overview:
- Responder at the far end of a generated microcoded core's output/input ports.
- The core raises requests through plain registered output ports using a toggle protocol. This block services each request against a local scratch memory and returns the result on ports the core reads as inputs.
- Gives microcode programs a handshaken memory/mailbox without any valid/ready wiring in the core.

Parameters:
- ADDR_W, 4, request address width.
- DATA_W, 8, data width.
- DEPTH, 12, number of memory entries (need not be a power of two; DEPTH <= 2**ADDR_W).
- WAIT_CYCLES, 2, extra service wait states per request (0..15).

Ports:
- clk  input  1  global clock.
- reset  input  1  synchronous, active-high reset.
- req_tog  input  1  request toggle; each transition marks one new request.
- req_we  input  1  1 = write, 0 = read; held stable by the core until ack.
- req_addr  input  ADDR_W  request address.
- req_wdata  input  DATA_W  write data.
- ack_tog  output  1  acknowledge toggle; transitions once per completed request.
- rsp_rdata  output  DATA_W  response data, valid once ack_tog has changed.
- rsp_err  output  1  1 = last request addressed an entry >= DEPTH.
- busy  output  1  high while a request is in service.
- overrun  output  1  sticky protocol-violation flag.

Behaviour:
- All state uses a single clock domain on clk. Reset is synchronous and active-high: it acts only on a rising clk edge with reset = 1.
- Values on reset:
  - ack_tog = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, overrun = 0.
  - Internal req_seen = 0, state = IDLE.
  - All DEPTH memory entries = 0.
- Reset asserted mid-service abandons the request; no ack is issued. The core must also reset its req_tog to 0.
- Pending request means req_tog != req_seen.
- FSM states and transitions:
  - IDLE: busy = 0. If a request is pending, at the edge:
    - latch req_we, req_addr and req_wdata;
    - set req_seen = req_tog and busy = 1;
    - load wait counter with WAIT_CYCLES;
    - go to WAIT, or straight to RESPOND if WAIT_CYCLES = 0.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESPOND on the next edge. This gives exactly WAIT_CYCLES cycles in WAIT.
  - RESPOND: one cycle. At the edge, perform the access, update rsp_*, invert ack_tog, clear busy, and go to IDLE.
- Access rules in RESPOND:
  - Read, addr < DEPTH: rsp_rdata = mem[addr], rsp_err = 0.
  - Write, addr < DEPTH: mem[addr] = wdata and rsp_rdata = previous mem[addr] (swap semantics), rsp_err = 0.
  - addr >= DEPTH, read or write: memory unchanged, rsp_rdata = 0, rsp_err = 1.
- Latency: with a request toggle first sampled at edge E0, ack_tog changes at edge E0 + WAIT_CYCLES + 1.
- Back-to-back: a new toggle presented in the cycle after ack is accepted from IDLE with no bubble beyond the IDLE cycle.
- Overrun:
  - If req_tog differs from req_seen while state != IDLE, set overrun = 1 (sticky, cleared only by reset).
  - The in-flight request completes normally.
  - The new toggle stays pending and is serviced next, using the values present on req_* at that IDLE cycle.
- Latched request fields are used for the access; req_* changes during service have no effect.
- rsp_rdata and rsp_err hold their values between responses.

Optional Feature:
- Macro: UCORE_RESP_PARITY_EN.
- Defined:
  - Adds output rsp_par (1 bit), the even parity (XOR reduction) of rsp_rdata.
  - rsp_par is registered and updated in the same edge as rsp_rdata; reset value 0.
  - On an error response, rsp_par = 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then read addr 3 (req_tog 0->1): ack_tog goes 0->1 exactly 3 edges after first sample; rsp_rdata = 0x00, rsp_err = 0, busy high for 3 cycles.
- Write 0xA5 to addr 5, then write 0x3C to addr 5, then read addr 5: rsp_rdata = 0x00, then 0xA5, then 0x3C; rsp_err = 0 for all three.
- Write 0x77 to addr 12 (DEPTH = 12): rsp_err = 1, rsp_rdata = 0; a following read of each addr 0..11 returns its prior value, with no corruption.
- Toggle req_tog again during WAIT of a read: overrun = 1 and stays 1; first ack as normal; second request serviced and acked, giving two ack_tog transitions in total.
- Assert reset for one cycle during WAIT after writing 0x11 to addr 2: no ack transition; ack_tog = 0, busy = 0; read of addr 2 returns 0x00.
- With WAIT_CYCLES = 0, run 4 back-to-back reads: each ack comes 1 edge after its request sample; with parity enabled, rsp_par = ^rsp_rdata for data 0x01, 0x03, 0xFF, 0x80 (1, 0, 0, 1).

Source files
------------

// File: rtl/ucore_port_responder_if.sv
// ucore_port_responder_if
// Request/response bundle between a microcoded core's output/input ports and
// the port responder. The core side uses the master modport, the responder
// uses the slave modport.
// Optional macro UCORE_RESP_PARITY_EN adds the rsp_par response bit.
interface ucore_port_responder_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   // Request, driven by the core
   logic              req_tog;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   // Response, driven by the responder
   logic              ack_tog;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;
   logic              overrun;
`ifdef UCORE_RESP_PARITY_EN
   logic              rsp_par;
`endif

`ifdef UCORE_RESP_PARITY_EN
   modport master (
      output req_tog, req_we, req_addr, req_wdata,
      input  ack_tog, rsp_rdata, rsp_err, busy, overrun, rsp_par
   );
   modport slave (
      input  req_tog, req_we, req_addr, req_wdata,
      output ack_tog, rsp_rdata, rsp_err, busy, overrun, rsp_par
   );
`else
   modport master (
      output req_tog, req_we, req_addr, req_wdata,
      input  ack_tog, rsp_rdata, rsp_err, busy, overrun
   );
   modport slave (
      input  req_tog, req_we, req_addr, req_wdata,
      output ack_tog, rsp_rdata, rsp_err, busy, overrun
   );
`endif
endinterface

// File: rtl/ucore_port_responder.sv
// ucore_port_responder
// Services toggle-protocol requests from a microcoded core against a local
// scratch memory (read, or write with swap semantics returning the old word)
// and answers with an acknowledge toggle plus response data.
// Optional macro UCORE_RESP_PARITY_EN adds a registered even-parity bit of
// the response data (forced to 0 on error responses).
module ucore_port_responder #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 12,
   parameter int WAIT_CYCLES = 2
) (
   input logic                   clk,
   input logic                   reset,
   ucore_port_responder_if.slave port
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                seen_q, seen_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                ack_q, ack_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                over_q, over_d;
`ifdef UCORE_RESP_PARITY_EN
   logic                par_q, par_d;
`endif

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DEPTH-1:0]    entry_sel;
   logic [DATA_W-1:0]   rd_val;
   logic                hit;
   logic                pending;
   logic                mem_we;

   // One-hot entry decode of the latched address; out-of-range addresses
   // select nothing, so they can never touch the memory.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
         localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
         assign entry_sel[gi] = (addr_q == IDX);
      end
   endgenerate

   assign hit     = ({1'b0, addr_q} < DEPTH_L);
   assign pending = (port.req_tog != seen_q);

   // Read mux: current contents of the addressed entry (old value for a swap).
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_sel[i]) begin
            rd_val = mem_q[i];
         end
      end
   end

   // Next-state and response logic for the accept / wait / respond sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      seen_d  = seen_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ack_d   = ack_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      busy_d  = busy_q;
      mem_we  = 1'b0;
`ifdef UCORE_RESP_PARITY_EN
      par_d   = par_q;
`endif
      // A toggle arriving while a request is still in service is a protocol
      // violation; it is remembered and serviced after the current one.
      over_d  = over_q | ((state_q != S_IDLE) && pending);

      case (state_q)
         S_IDLE: begin
            if (pending) begin
               we_d    = port.req_we;
               addr_d  = port.req_addr;
               wdata_d = port.req_wdata;
               seen_d  = port.req_tog;
               busy_d  = 1'b1;
               cnt_d   = WAIT_L;
               state_d = (WAIT_L == 4'd0) ? S_RESPOND : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = S_RESPOND;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESPOND: begin
            mem_we  = we_q & hit;
            rdata_d = hit ? rd_val : '0;
            err_d   = ~hit;
`ifdef UCORE_RESP_PARITY_EN
            par_d   = hit ? (^rd_val) : 1'b0;
`endif
            ack_d   = ~ack_q;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Control and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         seen_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seen_q  <= seen_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         over_q  <= over_d;
      end
   end

   // Scratch memory; every entry is cleared by reset, so it is kept in flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entry_sel[i]) begin
               mem_q[i] <= wdata_q;
            end
         end
      end
   end

`ifdef UCORE_RESP_PARITY_EN
   // Parity bit registered alongside the response data.
   always_ff @(posedge clk) begin
      if (reset) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign port.rsp_par = par_q;
`endif

   assign port.ack_tog   = ack_q;
   assign port.rsp_rdata = rdata_q;
   assign port.rsp_err   = err_q;
   assign port.busy      = busy_q;
   assign port.overrun   = over_q;

endmodule

// File: tb/tb_ucore_port_responder.sv
// tb_ucore_port_responder
// Two responders: instance A with the default two wait states, instance B
// with zero wait states. A transaction-level model predicts every output and
// is compared each cycle; directed transactions also check literal values.
// Parity checks are active when UCORE_RESP_PARITY_EN is defined.
module tb_ucore_port_responder;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ucore_port_responder_if #(.ADDR_W(4), .DATA_W(8)) ifa ();
   ucore_port_responder_if #(.ADDR_W(4), .DATA_W(8)) ifb ();

   ucore_port_responder #(.ADDR_W(4), .DATA_W(8), .DEPTH(12), .WAIT_CYCLES(2)) dut_a (
      .clk   (clk),
      .reset (reset),
      .port  (ifa)
   );

   ucore_port_responder #(.ADDR_W(4), .DATA_W(8), .DEPTH(12), .WAIT_CYCLES(0)) dut_b (
      .clk   (clk),
      .reset (reset),
      .port  (ifb)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // ---------------- transaction-level model ----------------
   logic [7:0] m_mem   [2][12];
   logic       m_seen  [2];
   logic       m_busy  [2];
   logic       m_ack   [2];
   logic       m_err   [2];
   logic       m_over  [2];
   logic       m_we    [2];
   logic [7:0] m_rdata [2];
   logic [7:0] m_wd    [2];
   logic [3:0] m_addr  [2];
   int         m_left  [2];

   // A request accepted at some edge is answered w+1 edges later.
   task automatic model_step(input int k, input logic tog, input logic we,
                             input logic [3:0] addr, input logic [7:0] wd, input int w);
      if (reset) begin
         m_seen[k] = 0; m_busy[k] = 0; m_ack[k] = 0; m_err[k] = 0;
         m_over[k] = 0; m_rdata[k] = 0; m_left[k] = 0;
         m_we[k] = 0; m_wd[k] = 0; m_addr[k] = 0;
         for (int i = 0; i < 12; i++) m_mem[k][i] = 8'h00;
      end else if (m_busy[k]) begin
         if (tog != m_seen[k]) m_over[k] = 1'b1;
         if (m_left[k] == 0) begin
            if (int'(m_addr[k]) < 12) begin
               m_rdata[k] = m_mem[k][int'(m_addr[k])];
               if (m_we[k]) m_mem[k][int'(m_addr[k])] = m_wd[k];
               m_err[k] = 1'b0;
            end else begin
               m_rdata[k] = 8'h00;
               m_err[k] = 1'b1;
            end
            m_ack[k] = ~m_ack[k];
            m_busy[k] = 1'b0;
         end else begin
            m_left[k] = m_left[k] - 1;
         end
      end else if (tog != m_seen[k]) begin
         m_we[k] = we; m_addr[k] = addr; m_wd[k] = wd;
         m_seen[k] = tog;
         m_busy[k] = 1'b1;
         m_left[k] = w;
      end
   endtask

   always @(posedge clk) begin
      model_step(0, ifa.req_tog, ifa.req_we, ifa.req_addr, ifa.req_wdata, 2);
      model_step(1, ifb.req_tog, ifb.req_we, ifb.req_addr, ifb.req_wdata, 0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("a_ack",   32'(ifa.ack_tog),   32'(m_ack[0]));
         check("a_rdata", 32'(ifa.rsp_rdata), 32'(m_rdata[0]));
         check("a_err",   32'(ifa.rsp_err),   32'(m_err[0]));
         check("a_busy",  32'(ifa.busy),      32'(m_busy[0]));
         check("a_over",  32'(ifa.overrun),   32'(m_over[0]));
         check("b_ack",   32'(ifb.ack_tog),   32'(m_ack[1]));
         check("b_rdata", 32'(ifb.rsp_rdata), 32'(m_rdata[1]));
         check("b_err",   32'(ifb.rsp_err),   32'(m_err[1]));
         check("b_busy",  32'(ifb.busy),      32'(m_busy[1]));
         check("b_over",  32'(ifb.overrun),   32'(m_over[1]));
`ifdef UCORE_RESP_PARITY_EN
         check("a_par", 32'(ifa.rsp_par), 32'(m_err[0] ? 1'b0 : ^m_rdata[0]));
         check("b_par", 32'(ifb.rsp_par), 32'(m_err[1] ? 1'b0 : ^m_rdata[1]));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic ack_of(input int k);
      return (k == 0) ? ifa.ack_tog : ifb.ack_tog;
   endfunction

   function automatic logic busy_of(input int k);
      return (k == 0) ? ifa.busy : ifb.busy;
   endfunction

   task automatic drive(input int k, input logic we, input logic [3:0] a, input logic [7:0] d);
      if (k == 0) begin
         ifa.req_we = we; ifa.req_addr = a; ifa.req_wdata = d; ifa.req_tog = ~ifa.req_tog;
      end else begin
         ifb.req_we = we; ifb.req_addr = a; ifb.req_wdata = d; ifb.req_tog = ~ifb.req_tog;
      end
   endtask

   // One request; lat = edges from the first sampling edge to the ack edge.
   task automatic xact(input int k, input logic we, input logic [3:0] a, input logic [7:0] d,
                       output int lat, output int busy_cnt);
      logic a0;
      bit done;
      a0 = ack_of(k);
      @(negedge clk);
      drive(k, we, a, d);
      lat = 0;
      busy_cnt = 0;
      done = 1'b0;
      while (!done) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy_of(k)) busy_cnt++;
         if (ack_of(k) != a0) begin
            done = 1'b1;
         end else if (lat > 40) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout inst=%0d addr=%0d got no ack expected ack", k, a);
            done = 1'b1;
         end
      end
      lat = lat - 1;
      $display("[TB] inst=%0d we=%0d addr=%0d wdata=%02h -> rdata=%02h err=%0d lat=%0d",
               k, we, a, d, (k == 0) ? ifa.rsp_rdata : ifb.rsp_rdata,
               (k == 0) ? ifa.rsp_err : ifb.rsp_err, lat);
   endtask

   logic [7:0] bvals [4];
   logic       bpar  [4];

   initial begin
      int lat, bc, acks;
      logic prev;

      ifa.req_tog = 0; ifa.req_we = 0; ifa.req_addr = 0; ifa.req_wdata = 0;
      ifb.req_tog = 0; ifb.req_we = 0; ifb.req_addr = 0; ifb.req_wdata = 0;
      bvals[0] = 8'h01; bvals[1] = 8'h03; bvals[2] = 8'hFF; bvals[3] = 8'h80;
      bpar[0] = 1'b1;   bpar[1] = 1'b0;   bpar[2] = 1'b0;   bpar[3] = 1'b1;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("rst_ack",   32'(ifa.ack_tog),   32'd0);
      check("rst_rdata", 32'(ifa.rsp_rdata), 32'd0);
      check("rst_err",   32'(ifa.rsp_err),   32'd0);
      check("rst_busy",  32'(ifa.busy),      32'd0);
      check("rst_over",  32'(ifa.overrun),   32'd0);

      // First read: latency WAIT_CYCLES+1, busy for three cycles
      xact(0, 1'b0, 4'd3, 8'h00, lat, bc);
      check("rd3_lat",   32'(lat), 32'd3);
      check("rd3_busy",  32'(bc),  32'd3);
      check("rd3_ack",   32'(ifa.ack_tog),   32'd1);
      check("rd3_rdata", 32'(ifa.rsp_rdata), 32'h00);
      check("rd3_err",   32'(ifa.rsp_err),   32'd0);

      // Swap writes
      xact(0, 1'b1, 4'd5, 8'hA5, lat, bc);
      check("wr5a_rdata", 32'(ifa.rsp_rdata), 32'h00);
      check("wr5a_err",   32'(ifa.rsp_err),   32'd0);
      xact(0, 1'b1, 4'd5, 8'h3C, lat, bc);
      check("wr5b_rdata", 32'(ifa.rsp_rdata), 32'hA5);
      check("wr5b_err",   32'(ifa.rsp_err),   32'd0);
      xact(0, 1'b0, 4'd5, 8'h00, lat, bc);
      check("rd5_rdata",  32'(ifa.rsp_rdata), 32'h3C);
      check("rd5_err",    32'(ifa.rsp_err),   32'd0);

      // Out-of-range write, then sweep every valid entry
      xact(0, 1'b1, 4'd12, 8'h77, lat, bc);
      check("wr12_err",   32'(ifa.rsp_err),   32'd1);
      check("wr12_rdata", 32'(ifa.rsp_rdata), 32'h00);
      for (int a = 0; a < 12; a++) begin
         xact(0, 1'b0, 4'(a), 8'h00, lat, bc);
         check("sweep_rdata", 32'(ifa.rsp_rdata), (a == 5) ? 32'h3C : 32'h00);
         check("sweep_err",   32'(ifa.rsp_err),   32'd0);
      end

      // Overrun: second toggle while the first read is waiting
      prev = ifa.ack_tog;
      acks = 0;
      @(negedge clk);
      drive(0, 1'b0, 4'd7, 8'h00);
      @(negedge clk);
      drive(0, 1'b0, 4'd5, 8'h00);
      repeat (20) begin
         @(posedge clk);
         #1;
         if (ifa.ack_tog != prev) acks++;
         prev = ifa.ack_tog;
      end
      $display("[TB] overrun sequence: acks=%0d overrun=%0d rdata=%02h", acks, ifa.overrun, ifa.rsp_rdata);
      check("ovr_acks",  32'(acks),          32'd2);
      check("ovr_flag",  32'(ifa.overrun),   32'd1);
      check("ovr_rdata", 32'(ifa.rsp_rdata), 32'h3C);
      check("ovr_busy",  32'(ifa.busy),      32'd0);

      // Reset during WAIT of a write abandons it
      @(negedge clk);
      drive(0, 1'b1, 4'd2, 8'h11);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      ifa.req_tog = 1'b0;
      ifb.req_tog = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("[TB] reset mid-service: ack=%0d busy=%0d overrun=%0d", ifa.ack_tog, ifa.busy, ifa.overrun);
      check("rstmid_ack",  32'(ifa.ack_tog), 32'd0);
      check("rstmid_busy", 32'(ifa.busy),    32'd0);
      check("rstmid_over", 32'(ifa.overrun), 32'd0);
      xact(0, 1'b0, 4'd2, 8'h00, lat, bc);
      check("rstmid_rd2", 32'(ifa.rsp_rdata), 32'h00);

      // Zero-wait instance: fill, then back-to-back reads
      for (int i = 0; i < 4; i++) begin
         xact(1, 1'b1, 4'(i), bvals[i], lat, bc);
         check("b_wr_lat", 32'(lat), 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
         xact(1, 1'b0, 4'(i), 8'h00, lat, bc);
         check("b_rd_lat",   32'(lat),           32'd1);
         check("b_rd_rdata", 32'(ifb.rsp_rdata), 32'(bvals[i]));
`ifdef UCORE_RESP_PARITY_EN
         check("b_rd_par",   32'(ifb.rsp_par),   32'(bpar[i]));
`endif
      end
      xact(1, 1'b0, 4'd15, 8'h00, lat, bc);
      check("b_oor_err",   32'(ifb.rsp_err),   32'd1);
      check("b_oor_rdata", 32'(ifb.rsp_rdata), 32'h00);

      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
